// File: rtl/y_mult_seq_pkg.sv
// Shared definitions for the sequential MULTU multiplier.
// Covers the datapath width and the controller state encoding.
package y_mult_seq_pkg;
    localparam int CPU_WIDTH = 32;

    typedef enum logic [1:0] {
        MULT_IDLE = 2'd0,
        MULT_RUN  = 2'd1,
        MULT_DONE = 2'd2
    } mult_state_e;
endpackage

// File: rtl/y_mult_seq_if.sv
// Request/response bundle between the datapath and the sequential multiplier.
// Carries start, the operands, busy/done and the HI/LO product halves.
interface y_mult_seq_if #(
    parameter int WIDTH = y_mult_seq_pkg::CPU_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] product_hi;
    logic [WIDTH-1:0] product_lo;

    modport master (
        output start, a, b,
        input  busy, done, product_hi, product_lo
    );

    modport slave (
        input  start, a, b,
        output busy, done, product_hi, product_lo
    );
endinterface

// File: rtl/y_mult_seq_yadder.sv
// WIDTH-bit ripple-carry adder (the yAdder role): z = a + b + cin, with carry-out.
// It is built from per-bit full-adder equations, so no '+' operator is inferred.
module y_mult_seq_yadder #(
    parameter int WIDTH = 32
) (
    output logic [WIDTH-1:0] z,
    output logic             cout,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin
);
    always_comb begin : ripple
        logic c;
        c = cin;
        z = '0;
        for (int i = 0; i < WIDTH; i++) begin
            z[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end
endmodule

// File: rtl/y_mult_seq.sv
// Unsigned shift-and-add multiplier that performs one adder pass per clock.
// It produces a 2*WIDTH product in HI/LO form under a start/busy/done handshake.
module y_mult_seq
    import y_mult_seq_pkg::*;
#(
    parameter int WIDTH = CPU_WIDTH
) (
    input  logic        clk,
    input  logic        rst_n,
    y_mult_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    mult_state_e      state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic             cout;

    assign addend = q_q[0] ? m_q : '0;

    y_mult_seq_yadder #(.WIDTH(WIDTH)) u_adder (
        .z    (sum),
        .cout (cout),
        .a    (acc_q),
        .b    (addend),
        .cin  (1'b0)
    );

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        count_d = count_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            MULT_IDLE, MULT_DONE: begin
                if (bus.start) begin
                    m_d     = bus.a;
                    q_d     = bus.b;
                    acc_d   = '0;
                    count_d = CW'(WIDTH - 1);
                    state_d = MULT_RUN;
                end else begin
                    state_d = MULT_IDLE;
                end
            end
            MULT_RUN: begin
                // {cout,sum,Q} shifted right by one: the carry becomes the new ACC MSB.
                acc_d = {cout, sum[WIDTH-1:1]};
                q_d   = {sum[0], q_q[WIDTH-1:1]};
                if (count_q == '0) begin
                    state_d = MULT_DONE;
                    hi_d    = {cout, sum[WIDTH-1:1]};
                    lo_d    = {sum[0], q_q[WIDTH-1:1]};
                end else begin
                    count_d = count_q - CW'(1);
                end
            end
            default: state_d = MULT_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MULT_IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.busy       = (state_q == MULT_RUN);
    assign bus.done       = (state_q == MULT_DONE);
    assign bus.product_hi = hi_q;
    assign bus.product_lo = lo_q;
endmodule

// File: tb/tb_y_mult_seq.sv
// Scoreboard bench for y_mult_seq: the stimulus queues a*b and the due cycle of each result.
// A monitor checks every done pulse against the head of that queue.
module tb_y_mult_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   busy_run = 0;

    logic [63:0] exp_q[$];
    int          due_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    y_mult_seq_if #(.WIDTH(32)) bus ();

    y_mult_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin : monitor
        logic [63:0] e;
        int          d;
        if (!rst_n) begin
            busy_run = 0;
        end else begin
            if (bus.busy) busy_run++;
            if (bus.done) begin
                check("busy_done_exclusive", {63'b0, bus.busy}, 64'd0);
                check("busy_length", busy_run, 64'd32);
                busy_run = 0;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done=1 expected no pulse (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    d = due_q.pop_front();
                    check("product", {bus.product_hi, bus.product_lo}, e);
                    check("latency", cyc, d);
                end
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit track);
        logic [63:0] wa, wb;
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        if (track) begin
            wa = {32'b0, a};
            wb = {32'b0, b};
            exp_q.push_back(wa * wb);
            due_q.push_back(cyc + 33);
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || bus.busy) && t < 200) begin
            @(posedge clk);
            t++;
        end
        if (t >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d results outstanding expected 0", exp_q.size());
            exp_q.delete();
            due_q.delete();
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b);
        issue(a, b, 1'b1);
        drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {63'b0, bus.busy}, 64'd0);
        check("rst_done", {63'b0, bus.done}, 64'd0);
        check("rst_hi", {32'b0, bus.product_hi}, 64'd0);
        check("rst_lo", {32'b0, bus.product_lo}, 64'd0);
        rst_n = 1'b1;

        run_op(32'd3, 32'd5);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(32'd0, 32'h1234_5678);
        run_op(32'h8000_0000, 32'd2);

        // Start during RUN must be ignored.
        issue(32'd7, 32'd6, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.a     = 32'd9;
        bus.b     = 32'd9;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        drain();

        // Reset in the middle of an operation aborts it silently.
        issue(32'd100, 32'd100, 1'b0);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {63'b0, bus.busy}, 64'd0);
        check("abort_done", {63'b0, bus.done}, 64'd0);
        check("abort_hi", {32'b0, bus.product_hi}, 64'd0);
        check("abort_lo", {32'b0, bus.product_lo}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        run_op(32'd2, 32'd3);

        // Back-to-back: start held through the done cycle.
        begin : b2b
            logic [63:0] wa, wb;
            @(posedge clk);
            #1;
            bus.start = 1'b1;
            bus.a     = 32'd10;
            bus.b     = 32'd10;
            exp_q.push_back(64'd100);
            due_q.push_back(cyc + 33);
            repeat (33) @(posedge clk);
            #1;
            check("b2b_done_cycle", {63'b0, bus.done}, 64'd1);
            bus.a = 32'd11;
            bus.b = 32'd11;
            wa = 64'd11;
            wb = 64'd11;
            exp_q.push_back(wa * wb);
            due_q.push_back(cyc + 33);
            @(posedge clk);
            #1;
            check("b2b_busy_next", {63'b0, bus.busy}, 64'd1);
            bus.start = 1'b0;
            drain();
        end

        for (int i = 0; i < 50; i++) begin
            run_op($urandom, $urandom);
        end

        repeat (5) @(posedge clk);
        check("queue_empty", exp_q.size(), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
